// File: rtl/writeback_unit_pkg.sv
// Shared core constants for the writeback stage: data widths, load funct3
// encodings and the writeback FSM state type.
package writeback_unit_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        WAIT_LOAD = 1'b1
    } wb_state_e;

endpackage

// File: rtl/writeback_unit_if.sv
// Execute-to-writeback retire bus. Handshake: a transfer happens in any cycle
// where ex_valid_in && ex_ready_out; execute holds all fields stable while valid and not ready.
interface writeback_unit_if;
    import writeback_unit_pkg::*;

    logic                  ex_valid_in;
    logic                  ex_ready_out;
    logic                  ex_wb_en_in;
    logic                  ex_is_load_in;
    logic [REG_ADDR_W-1:0] ex_rd_addr_in;
    logic [XLEN-1:0]       ex_result_in;
    logic [2:0]            ex_funct3_in;
    logic [1:0]            ex_addr_lsb_in;

    modport master (
        output ex_valid_in, ex_wb_en_in, ex_is_load_in, ex_rd_addr_in,
               ex_result_in, ex_funct3_in, ex_addr_lsb_in,
        input  ex_ready_out
    );

    modport slave (
        input  ex_valid_in, ex_wb_en_in, ex_is_load_in, ex_rd_addr_in,
               ex_result_in, ex_funct3_in, ex_addr_lsb_in,
        output ex_ready_out
    );

endinterface

// File: rtl/writeback_unit_load_extender.sv
// Combinational load-data formatter: picks the byte/halfword lane from the raw
// aligned word and sign- or zero-extends it to XLEN.
module writeback_unit_load_extender
    import writeback_unit_pkg::*;
(
    input  logic [XLEN-1:0] raw_word,
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lsb,
    output logic [XLEN-1:0] ext_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = raw_word[{addr_lsb, 3'b000} +: 8];
        half_sel = addr_lsb[1] ? raw_word[31:16] : raw_word[15:0];
        // Reserved encodings fall through to the word path.
        case (funct3)
            LB:      ext_word = {{24{byte_sel[7]}}, byte_sel};
            LH:      ext_word = {{16{half_sel[15]}}, half_sel};
            LBU:     ext_word = {24'd0, byte_sel};
            LHU:     ext_word = {16'd0, half_sel};
            default: ext_word = raw_word;
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// Final integer-pipeline stage: retires ALU results immediately, parks loads
// until the data memory responds (or times out), and drives the register-file write port.
module writeback_unit
    import writeback_unit_pkg::*;
#(
    parameter int LOAD_TIMEOUT = 16,
    parameter int CNT_W        = 5
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    writeback_unit_if.slave       ex,
    input  logic                  dmem_rvalid_in,
    input  logic [XLEN-1:0]       dmem_rdata_in,
    output logic [REG_ADDR_W-1:0] rd_addr_out,
    output logic [XLEN-1:0]       rd_out,
    output logic                  wr_en_out,
    output logic                  pend_valid_out,
    output logic [REG_ADDR_W-1:0] pend_rd_out,
    output logic                  load_err_out,
    output wb_state_e             dbg_state_out
);

    wb_state_e             state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;

    logic [REG_ADDR_W-1:0] lat_rd;
    logic [2:0]            lat_funct3;
    logic [1:0]            lat_lsb;
    logic                  lat_wb_en;

    logic                  hs;
    logic                  load_accept;
    logic                  alu_wr;
    logic                  load_done;
    logic                  load_abort;
    logic                  wr_nxt;
    logic [REG_ADDR_W-1:0] addr_nxt;
    logic [XLEN-1:0]       data_nxt;
    logic [XLEN-1:0]       ext_word;
    logic                  timeout_hit;

    writeback_unit_load_extender u_ext (
        .raw_word (dmem_rdata_in),
        .funct3   (lat_funct3),
        .addr_lsb (lat_lsb),
        .ext_word (ext_word)
    );

    assign timeout_hit   = (cnt == CNT_W'(LOAD_TIMEOUT - 1));
    assign dbg_state_out = state;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // rvalid is checked before the timeout so a same-cycle response still writes.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (ex.ex_valid_in && ex.ex_is_load_in) begin
                    state_nxt = WAIT_LOAD;
                    cnt_nxt   = '0;
                end
            end
            WAIT_LOAD: begin
                cnt_nxt = cnt + CNT_W'(1);
                if (dmem_rvalid_in || timeout_hit) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ex.ex_ready_out = (state == IDLE);
        hs              = ex.ex_valid_in && (state == IDLE);
        load_accept     = hs && ex.ex_is_load_in;
        alu_wr          = hs && !ex.ex_is_load_in && ex.ex_wb_en_in &&
                          (ex.ex_rd_addr_in != '0);
        load_done       = (state == WAIT_LOAD) && dmem_rvalid_in;
        load_abort      = (state == WAIT_LOAD) && !dmem_rvalid_in && timeout_hit;
        wr_nxt          = alu_wr || (load_done && lat_wb_en);
        addr_nxt        = alu_wr ? ex.ex_rd_addr_in : lat_rd;
        data_nxt        = alu_wr ? ex.ex_result_in  : ext_word;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            lat_rd     <= '0;
            lat_funct3 <= LW;
            lat_lsb    <= '0;
            lat_wb_en  <= 1'b0;
        end else if (load_accept) begin
            lat_rd     <= ex.ex_rd_addr_in;
            lat_funct3 <= ex.ex_funct3_in;
            lat_lsb    <= ex.ex_addr_lsb_in;
            lat_wb_en  <= ex.ex_wb_en_in && (ex.ex_rd_addr_in != '0);
        end
    end

    // Address and data only move on a real write; the register file bypasses them.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_en_out      <= 1'b0;
            rd_addr_out    <= '0;
            rd_out         <= '0;
            load_err_out   <= 1'b0;
            pend_valid_out <= 1'b0;
            pend_rd_out    <= '0;
        end else begin
            wr_en_out    <= wr_nxt;
            load_err_out <= load_abort;
            if (wr_nxt) begin
                rd_addr_out <= addr_nxt;
                rd_out      <= data_nxt;
            end
            if (load_accept) begin
                pend_valid_out <= 1'b1;
                pend_rd_out    <= ex.ex_rd_addr_in;
            end else if (load_done || load_abort) begin
                pend_valid_out <= 1'b0;
                pend_rd_out    <= '0;
            end
        end
    end

endmodule
